// File: rtl/nano_mem_pkg.sv
// Shared types and constants for the nano-cpu memory arbiter.
package nano_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LSU    = 1'b1;

    localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a lone requester always wins,
// a tie goes to the port that did not win last time.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (&valid) grant = last_grant ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the
// instruction-fetch port (0) and the load/store port (1), one transaction at a time.
module mem_arbiter
    import nano_mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic              p0_req_we,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_rdata,
    output logic              p0_resp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic              p1_req_we,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_rdata,
    output logic              p1_resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         port_q, port_d;
    logic                         we_q, we_d;
    logic                         last_q, last_d;
    logic [1:0]                   resp_vld_q, resp_vld_d;
    logic [1:0]                   resp_err_q, resp_err_d;
    logic [1:0][DATA_W-1:0]       resp_rdata_q, resp_rdata_d;

    logic [1:0]        gnt;
    logic              gnt_port;
    logic              can_accept;
    logic              accept;
    logic              aligned;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr (
        .valid      ({p1_req_valid, p0_req_valid}),
        .last_grant (last_q),
        .grant      (gnt)
    );

    assign gnt_port   = gnt[1] ? PORT_LSU : PORT_IFETCH;
    assign can_accept = (state_q == IDLE) || (state_q == RESP);
    assign accept     = can_accept && (|gnt);

    assign sel_addr  = gnt_port ? p1_req_addr  : p0_req_addr;
    assign sel_we    = gnt_port ? p1_req_we    : p0_req_we;
    assign sel_wdata = gnt_port ? p1_req_wdata : p0_req_wdata;
    assign aligned   = (sel_addr[1:0] == 2'b00);

    assign p0_req_ready = can_accept && gnt[0];
    assign p1_req_ready = can_accept && gnt[1];

    // Memory strobes are gated so the bus idles at zero between accesses.
    assign mem_en    = accept && aligned;
    assign mem_we    = mem_en && sel_we;
    assign mem_addr  = mem_en ? sel_addr[ADDR_W-1:2] : '0;
    assign mem_wdata = mem_en ? sel_wdata : '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        we_d         = we_q;
        last_d       = last_q;
        resp_vld_d   = '0;
        resp_err_d   = '0;
        resp_rdata_d = '0;

        case (state_q)
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d              = RESP;
                    resp_vld_d[port_q]   = 1'b1;
                    resp_rdata_d[port_q] = we_q ? '0 : mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // A new accept in RESP overrides the fall-back to IDLE.
        if (accept) begin
            port_d = gnt_port;
            last_d = gnt_port;
            we_d   = sel_we;
            if (aligned) begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = WAIT;
            end else begin
                state_d              = RESP;
                resp_vld_d[gnt_port] = 1'b1;
                resp_err_d[gnt_port] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            port_q       <= PORT_IFETCH;
            we_q         <= 1'b0;
            last_q       <= PORT_LSU;
            resp_vld_q   <= '0;
            resp_err_q   <= '0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            we_q         <= we_d;
            last_q       <= last_d;
            resp_vld_q   <= resp_vld_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign p0_resp_valid = resp_vld_q[0];
    assign p0_resp_err   = resp_err_q[0];
    assign p0_resp_rdata = resp_rdata_q[0];
    assign p1_resp_valid = resp_vld_q[1];
    assign p1_resp_err   = resp_err_q[1];
    assign p1_resp_rdata = resp_rdata_q[1];

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-port word memory between the instruction-fetch path (port 0) and the load/store path (port 1) of the nano-cpu. It accepts at most one transaction at a time, drives the memory for a fixed read latency, and returns a registered response to the granted port. Misaligned accesses are rejected with an error response and never reach memory. It sits between the processor core and the memory macro, replacing direct array indexing in the core.

## Interface
- ADDR_W, 16, byte-address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles, legal range 1..7
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_req_valid / p1_req_valid  in  1  request present
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle; combinational from the valids and state
- p0_req_addr / p1_req_addr  in  ADDR_W  byte address, must be word-aligned
- p0_req_we / p1_req_we  in  1  1 = write, 0 = read
- p0_req_wdata / p1_req_wdata  in  DATA_W  write data
- p0_resp_valid / p1_resp_valid  out  1  one-cycle response pulse
- p0_resp_rdata / p1_resp_rdata  out  DATA_W  read data; 0 for writes and errors
- p0_resp_err / p1_resp_err  out  1  misaligned address, qualified by resp_valid
- mem_en  out  1  memory access strobe, one cycle
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W-2  word address (req_addr[ADDR_W-1:2])
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  valid exactly MEM_LAT cycles after mem_en with mem_we=0

## Operation
- States: IDLE, WAIT, RESP.
- An accept (handshake) is allowed in IDLE or RESP. The grant is issued combinationally:
  - Only one valid: grant that port.
  - Both valid: grant the port not equal to last_grant.
  - p*_req_ready equals the grant and is 0 for a non-granted port.
- On an aligned accept:
  - mem_en=1 in the same cycle, with mem_we/mem_addr/mem_wdata taken from the granted port.
  - Capture the port and we; load the counter with MEM_LAT; go to WAIT.
- On a misaligned accept (addr[1:0]≠0):
  - mem_en stays 0.
  - Capture the port and set err; go directly to RESP.
- WAIT: the counter decrements every cycle. In the cycle it equals 1:
  - Register mem_rdata (read) or 0 (write) into the response register.
  - Go to RESP.
- RESP: resp_valid=1 for the captured port only, with rdata and err from the response register.
  - A new accept in the same cycle moves to WAIT or RESP as above.
  - Otherwise go to IDLE.
- last_grant updates on every accept, including misaligned accepts.
- Reset values: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie; response register 0. Reset mid-transaction discards it and no response is issued.
- Only one transaction is ever outstanding; the memory never sees overlapping accesses.

## Timing
- Accept at cycle T: mem_en at T; resp_valid at T+MEM_LAT+1 (aligned), or T+1 (misaligned).
- Back-to-back throughput: one aligned transaction per MEM_LAT+1 cycles, because the next accept coincides with the previous resp_valid.
- resp_valid, resp_rdata and resp_err are registered outputs. The mem_* outputs and req_ready are combinational.
- Requests whose valid drops before ready are not remembered. The arbiter places no stability requirement on requesters.

## Structure
- Package nano_mem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - port index constants PORT_IFETCH=0 and PORT_LSU=1;
  - the latency-counter width (3).
- One sub-module is natural: rr_arb2, a 2-requester round-robin grant (valids plus last_grant → one-hot grant). Everything else lives in mem_arbiter.

## Test plan
- Reset, then a p0 read of addr 0x0010 with the memory model returning 0xDEADBEEF at MEM_LAT=1 → mem_en at T, mem_addr=0x0004, p0_resp_valid at T+2 with rdata 0xDEADBEEF and err=0.
- p0 and p1 both hold valid continuously, each issuing 4 reads → grants alternate 0,1,0,1,… starting with p0. Accepts occur every 2 cycles and each resp_valid goes only to the port that issued the request.
- p1 write of 0x12345678 to 0x0020, then p1 read of 0x0020 → mem_we=1 with wdata 0x12345678; the write response has rdata 0; the read returns 0x12345678.
- p1 read of 0x0022 → no mem_en, p1_resp_valid at T+1 with err=1 and rdata 0. The next tie is granted to p0.
- MEM_LAT=3 with a p0 read accepted at T; rst_n asserted at T+2 → no resp_valid is ever issued, all outputs are 0, and the first post-reset tie is granted to p0.
- MEM_LAT=2 with p0 valid asserted only in the RESP cycle of a p1 read → p0 is accepted in that same cycle (mem_en coincides with p1_resp_valid).
